// File: rtl/mux_nby1_tdm.sv
// mux_nby1_tdm: N-channel, W-bit multiplexer with a registered output and a
// time-division scan sequencer.
//
// Modes
//   mode = 0 : manual select. The channel chosen by s appears on y one clock later.
//   mode = 1 : auto scan. The block steps through channels 0..N-1 and holds each
//              one for DWELL cycles. y re-samples the live data of the current
//              channel on every cycle.
//
// Parameters
//   N     number of input channels (N >= 2)
//   W     data width per channel
//   SW    channel-index width, derived from N (do not override)
//   DWELL cycles each channel is held in scan mode (DWELL >= 1)
//
// Ports
//   clk      rising-edge clock
//   rst      synchronous, active-high reset; takes priority over en
//   en       clock enable; when low, all state holds and frame is forced to 0
//   mode     0 = manual select, 1 = auto scan
//   s        manual channel select; ignored in scan mode
//   i        packed channel data; channel k is i[k*W +: W]
//   y        registered selected data
//   y_valid  y holds data from a legal channel
//   ch       index of the channel currently driven on y
//   frame    one-cycle pulse on the first cycle channel 0 appears in a scan pass
//   y_par    (only with MUX_PARITY_EN) XOR-reduce of y; 0 whenever y_valid = 0
//
// Optional feature: define MUX_PARITY_EN to add the y_par output.
module mux_nby1_tdm #(
  parameter int unsigned N     = 4,
  parameter int unsigned W     = 1,
  parameter int unsigned SW    = $clog2(N),
  parameter int unsigned DWELL = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic           mode,
  input  logic [SW-1:0]  s,
  input  logic [N*W-1:0] i,
  output logic [W-1:0]   y,
  output logic           y_valid,
  output logic [SW-1:0]  ch,
  output logic           frame
`ifdef MUX_PARITY_EN
  ,
  output logic           y_par
`endif
);

  // Dwell counter width; at least one bit so DWELL = 1 still elaborates.
  localparam int unsigned CW = (DWELL > 1) ? $clog2(DWELL) : 1;

  typedef enum logic [0:0] {
    ST_MANUAL = 1'b0,
    ST_SCAN   = 1'b1
  } state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [W-1:0]   y_d;
  logic           y_valid_d;
  logic [SW-1:0]  ch_d;
  logic           frame_d;

  // Select one channel from the packed bus; indices >= N return zero.
  function automatic logic [W-1:0] pick(input logic [SW-1:0] idx,
                                        input logic [N*W-1:0] bus);
    logic [W-1:0] r;
    r = '0;
    for (int k = 0; k < N; k++) begin
      if (idx == SW'(k)) r = bus[k*W +: W];
    end
    return r;
  endfunction

  // An index is legal when it names an existing channel.
  function automatic logic legal(input logic [SW-1:0] idx);
    return (32'(idx) < N);
  endfunction

  // Next channel in scan order, wrapping N-1 back to 0.
  function automatic logic [SW-1:0] next_ch(input logic [SW-1:0] cur);
    if (cur == SW'(N - 1)) return '0;
    return cur + SW'(1);
  endfunction

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_MANUAL;
      cnt_q   <= '0;
      y       <= '0;
      y_valid <= 1'b0;
      ch      <= '0;
      frame   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      y       <= y_d;
      y_valid <= y_valid_d;
      ch      <= ch_d;
      frame   <= frame_d;
    end
  end

  // Next-state and next-output logic. Mode changes take effect on the same
  // edge, so the mode input decides the branch rather than the current state.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    y_d       = y;
    y_valid_d = y_valid;
    ch_d      = ch;
    frame_d   = 1'b0;

    if (en) begin
      if (!mode) begin
        // Manual: follow s directly; leaving scan discards the dwell count.
        state_d = ST_MANUAL;
        cnt_d   = '0;
        ch_d    = s;
        if (legal(s)) begin
          y_d       = pick(s, i);
          y_valid_d = 1'b1;
        end else begin
          y_d       = '0;
          y_valid_d = 1'b0;
        end
      end else begin
        if (state_q == ST_MANUAL) begin
          // Scan entry always starts a fresh pass at channel 0.
          state_d = ST_SCAN;
          cnt_d   = '0;
          ch_d    = '0;
          frame_d = 1'b1;
        end else if (cnt_q == CW'(DWELL - 1)) begin
          cnt_d   = '0;
          ch_d    = next_ch(ch);
          frame_d = (ch == SW'(N - 1));
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
        // Scan channels are always legal; y tracks live data within the dwell.
        y_d       = pick(ch_d, i);
        y_valid_d = 1'b1;
      end
    end
  end

`ifdef MUX_PARITY_EN
  logic y_par_d;

  // Parity follows the data being loaded into y and is masked when invalid.
  always_comb begin
    y_par_d = y_valid_d & (^y_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      y_par <= 1'b0;
    end else begin
      y_par <= y_par_d;
    end
  end
`endif

endmodule

// File: tb/tb_mux_nby1_tdm.sv
// Directed bench for mux_nby1_tdm: a 4x8-bit instance with DWELL = 3 and a
// 3x4-bit instance with DWELL = 2 (non power-of-two channel count).
module tb_mux_nby1_tdm;

  logic clk;

  // Instance A: N = 4, W = 8, DWELL = 3
  logic        rst_a, en_a, mode_a;
  logic [1:0]  s_a;
  logic [31:0] i_a;
  logic [7:0]  y_a;
  logic        yv_a;
  logic [1:0]  ch_a;
  logic        fr_a;

  // Instance B: N = 3, W = 4, DWELL = 2
  logic        rst_b, en_b, mode_b;
  logic [1:0]  s_b;
  logic [11:0] i_b;
  logic [3:0]  y_b;
  logic        yv_b;
  logic [1:0]  ch_b;
  logic        fr_b;

`ifdef MUX_PARITY_EN
  logic        par_a, par_b;
`endif

  int total = 0;
  int bad   = 0;

  mux_nby1_tdm #(.N(4), .W(8), .DWELL(3)) dut_a (
    .clk(clk), .rst(rst_a), .en(en_a), .mode(mode_a), .s(s_a), .i(i_a),
    .y(y_a), .y_valid(yv_a), .ch(ch_a), .frame(fr_a)
`ifdef MUX_PARITY_EN
    , .y_par(par_a)
`endif
  );

  mux_nby1_tdm #(.N(3), .W(4), .DWELL(2)) dut_b (
    .clk(clk), .rst(rst_b), .en(en_b), .mode(mode_b), .s(s_b), .i(i_b),
    .y(y_b), .y_valid(yv_b), .ch(ch_b), .frame(fr_b)
`ifdef MUX_PARITY_EN
    , .y_par(par_b)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_a(input string tag, input logic [7:0] ey, input logic ev,
                       input logic [1:0] ec, input logic ef);
    chk({tag, ".y"},       32'(y_a),  32'(ey));
    chk({tag, ".y_valid"}, 32'(yv_a), 32'(ev));
    chk({tag, ".ch"},      32'(ch_a), 32'(ec));
    chk({tag, ".frame"},   32'(fr_a), 32'(ef));
  endtask

  task automatic chk_b(input string tag, input logic [3:0] ey, input logic ev,
                       input logic [1:0] ec, input logic ef);
    chk({tag, ".y"},       32'(y_b),  32'(ey));
    chk({tag, ".y_valid"}, 32'(yv_b), 32'(ev));
    chk({tag, ".ch"},      32'(ch_b), 32'(ec));
    chk({tag, ".frame"},   32'(fr_b), 32'(ef));
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [1:0] scan_ch_a [13] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd2,
                                  2'd2, 2'd2, 2'd3, 2'd3, 2'd3, 2'd0};
  logic [7:0] dat_a [4]      = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
  logic [1:0] scan_ch_b [7]  = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd0};
  logic [3:0] dat_b [3]      = '{4'h3, 4'h6, 4'h9};

  initial begin
    rst_a = 1'b1; en_a = 1'b1; mode_a = 1'b1; s_a = 2'd2; i_a = 32'h1234_5678;
    rst_b = 1'b1; en_b = 1'b1; mode_b = 1'b0; s_b = 2'd1; i_b = 12'hABC;

    // Reset held for three cycles with arbitrary inputs.
    for (int k = 0; k < 3; k++) begin
      step();
      chk_a("reset", 8'h00, 1'b0, 2'd0, 1'b0);
`ifdef MUX_PARITY_EN
      chk("reset.y_par", 32'(par_a), 32'd0);
`endif
    end

    // Manual select through all four channels.
    rst_a = 1'b0; mode_a = 1'b0; i_a = 32'hDDCC_BBAA;
    for (int k = 0; k < 4; k++) begin
      s_a = 2'(k);
      step();
      chk_a("manual", dat_a[k], 1'b1, 2'(k), 1'b0);
    end

    // Full scan pass plus wrap to channel 0.
    mode_a = 1'b1;
    for (int k = 0; k < 13; k++) begin
      step();
      chk_a("scan", dat_a[scan_ch_a[k]], 1'b1, scan_ch_a[k], (k == 0) || (k == 12));
    end

    // Live data is tracked within the dwell.
    i_a[7:0] = 8'h5A;
    step();
    chk_a("scan_live", 8'h5A, 1'b1, 2'd0, 1'b0);
    i_a[7:0] = 8'hAA;
    step();
    chk_a("scan_live2", 8'hAA, 1'b1, 2'd0, 1'b0);
    step(); step(); step();
    chk_a("scan_ch1_end", 8'hBB, 1'b1, 2'd1, 1'b0);
    step(); step();
    chk_a("scan_ch2_mid", 8'hCC, 1'b1, 2'd2, 1'b0);

    // Freeze mid-dwell on channel 2; input changes must not reach y.
    en_a = 1'b0; i_a[23:16] = 8'h11;
    for (int k = 0; k < 5; k++) begin
      step();
      chk_a("freeze", 8'hCC, 1'b1, 2'd2, 1'b0);
    end
    i_a[23:16] = 8'hCC; en_a = 1'b1;
    step();
    chk_a("resume_dwell", 8'hCC, 1'b1, 2'd2, 1'b0);
    step();
    chk_a("resume_next", 8'hDD, 1'b1, 2'd3, 1'b0);
    step();
    chk_a("ch3_mid", 8'hDD, 1'b1, 2'd3, 1'b0);

    // Back to manual mid-dwell: s takes effect on the same edge.
    mode_a = 1'b0; s_a = 2'd1;
    step();
    chk_a("to_manual", 8'hBB, 1'b1, 2'd1, 1'b0);

    // Reset mid-scan restarts the next pass at channel 0.
    mode_a = 1'b1;
    step(); step(); step(); step();
    chk_a("pre_rst_ch1", 8'hBB, 1'b1, 2'd1, 1'b0);
    rst_a = 1'b1;
    step();
    chk_a("mid_rst", 8'h00, 1'b0, 2'd0, 1'b0);
    rst_a = 1'b0;
    step();
    chk_a("rescan_entry", 8'hAA, 1'b1, 2'd0, 1'b1);
    step();
    chk_a("rescan_hold", 8'hAA, 1'b1, 2'd0, 1'b0);

    // Enable low in manual mode holds the selection.
    mode_a = 1'b0; s_a = 2'd1;
    step();
    chk_a("manual_again", 8'hBB, 1'b1, 2'd1, 1'b0);
    en_a = 1'b0; s_a = 2'd3;
    step();
    chk_a("manual_frozen", 8'hBB, 1'b1, 2'd1, 1'b0);
    en_a = 1'b1;

`ifdef MUX_PARITY_EN
    s_a = 2'd0; i_a[7:0] = 8'hA7;
    step();
    chk("par_a7", 32'(par_a), 32'd1);
    i_a[7:0] = 8'h33;
    step();
    chk("par_33", 32'(par_a), 32'd0);
`endif

    // Instance B: reset values, illegal select, recovery, non power-of-two scan.
    chk_b("b_reset", 4'h0, 1'b0, 2'd0, 1'b0);
    rst_b = 1'b0; i_b = 12'h963; s_b = 2'd2;
    step();
    chk_b("b_sel2", 4'h9, 1'b1, 2'd2, 1'b0);
    s_b = 2'd3;
    step();
    chk_b("b_illegal", 4'h0, 1'b0, 2'd3, 1'b0);
`ifdef MUX_PARITY_EN
    chk("b_illegal.y_par", 32'(par_b), 32'd0);
`endif
    s_b = 2'd2;
    step();
    chk_b("b_recover", 4'h9, 1'b1, 2'd2, 1'b0);
    mode_b = 1'b1;
    for (int k = 0; k < 7; k++) begin
      step();
      chk_b("b_scan", dat_b[scan_ch_b[k]], 1'b1, scan_ch_b[k], (k == 0) || (k == 6));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
